// File: rtl/mem_dbus_if.sv
// mem_dbus_if: req/gnt/rvalid data-bus handshake between the MEM-stage controller and memory
interface mem_dbus_if #(parameter int ADDR_W = 32);
  logic              req;
  logic              we;
  logic [3:0]        be;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              gnt;
  logic              rvalid;
  logic [31:0]       rdata;
  modport master(output req, we, be, addr, wdata, input gnt, rvalid, rdata);
  modport slave(input req, we, be, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_dbus_ctrl.sv
// mem_dbus_ctrl: MEM-stage load/store alignment check, single bus transaction and pipeline stall
module mem_dbus_ctrl #(parameter int ADDR_W = 32) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              op_valid,
  input  logic [3:0]        op_type,
  input  logic [ADDR_W-1:0] op_addr,
  input  logic [31:0]       op_wdata,
  output logic              stall_req,
  output logic              done,
  output logic [31:0]       ld_data,
  output logic              exc_adel,
  output logic              exc_ades,
  output logic [ADDR_W-1:0] bad_vaddr,
  mem_dbus_if.master        dbus
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, DRAIN} state_t;
  state_t      state;
  logic        is_load, is_store, is_b, is_h, mis, accept, go;
  logic [2:0]  lt;
  logic [1:0]  la;
  logic [3:0]  be_n;
  logic [31:0] wd_n, fmt;
  logic [7:0]  b;
  logic [15:0] h;
  // decode the MEM op, flag misalignment and build lane enables, store data and the load result
  always_comb begin
    is_load = op_type <= 4'd4;
    is_store = op_type inside {4'h8, 4'h9, 4'hA};
    is_b = op_type inside {4'h0, 4'h1, 4'h8};
    is_h = op_type inside {4'h2, 4'h3, 4'h9};
    mis = is_b ? 1'b0 : is_h ? op_addr[0] : |op_addr[1:0];
    accept = state == IDLE && op_valid && (is_load || is_store) && !flush;
    go = accept && !mis;
    exc_adel = accept && is_load && mis;
    exc_ades = accept && is_store && mis;
    bad_vaddr = (exc_adel || exc_ades) ? op_addr : '0;
    stall_req = go || state inside {REQ, WAIT, DRAIN};
    be_n = is_b ? 4'b0001 << op_addr[1:0] : is_h ? (op_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wd_n = is_b ? {4{op_wdata[7:0]}} : is_h ? {2{op_wdata[15:0]}} : op_wdata;
    b = dbus.rdata[{la, 3'b000} +: 8];
    h = la[1] ? dbus.rdata[31:16] : dbus.rdata[15:0];
    fmt = lt == 3'd0 ? {{24{b[7]}}, b} : lt == 3'd1 ? {24'b0, b} :
          lt == 3'd2 ? {{16{h[15]}}, h} : lt == 3'd3 ? {16'b0, h} : dbus.rdata;
  end
  assign done = state == DONE;
  assign dbus.req = state == REQ;
  // transaction sequencer: latch the op, hold the request until gnt, then await or discard read data
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ld_data <= '0;
      dbus.we <= 1'b0;
      dbus.be <= '0;
      dbus.addr <= '0;
      dbus.wdata <= '0;
      lt <= '0;
      la <= '0;
    end else begin
      case (state)
        IDLE: if (go) begin
          state <= REQ;
          dbus.we <= is_store;
          dbus.be <= be_n;
          dbus.addr <= {op_addr[ADDR_W-1:2], 2'b00};
          dbus.wdata <= wd_n;
          lt <= op_type[2:0];
          la <= op_addr[1:0];
        end
        REQ: if (dbus.gnt) state <= dbus.we ? (flush ? IDLE : DONE) : (flush ? DRAIN : WAIT);
             else if (flush) state <= IDLE;
        WAIT: if (flush) state <= dbus.rvalid ? IDLE : DRAIN;
              else if (dbus.rvalid) begin
                ld_data <= fmt;
                state <= DONE;
              end
        DRAIN: if (dbus.rvalid) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_dbus_ctrl.sv
// tb_mem_dbus_ctrl: randomized scoreboard bench for the MEM-stage data-bus controller
module tb_mem_dbus_ctrl;
  logic clk = 0, rst = 1, flush = 0, op_valid = 0;
  logic [3:0] op_type = 0;
  logic [31:0] op_addr = 0, op_wdata = 0;
  logic stall_req, done, exc_adel, exc_ades;
  logic [31:0] ld_data, bad_vaddr;
  int vectors = 0, miscompares = 0;
  typedef struct {logic we; logic [3:0] be; logic [31:0] addr, wdata;} txn_t;
  txn_t bus_q[$];
  txn_t mt;
  logic [31:0] done_q[$];
  logic [32:0] exc_q[$];
  logic [32:0] me;
  logic [31:0] model_ld = 0;

  mem_dbus_if #(.ADDR_W(32)) bus();
  mem_dbus_ctrl #(.ADDR_W(32)) dut(.clk(clk), .rst(rst), .flush(flush), .op_valid(op_valid),
    .op_type(op_type), .op_addr(op_addr), .op_wdata(op_wdata), .stall_req(stall_req), .done(done),
    .ld_data(ld_data), .exc_adel(exc_adel), .exc_ades(exc_ades), .bad_vaddr(bad_vaddr), .dbus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sz(input logic [3:0] t);
    case (t)
      4'h0, 4'h1, 4'h8: return 1;
      4'h2, 4'h3, 4'h9: return 2;
      4'h4, 4'hA: return 4;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] mask(input int n);
    return n == 4 ? 32'hFFFF_FFFF : (32'd1 << (8 * n)) - 1;
  endfunction

  function automatic logic [31:0] ld_m(input logic [3:0] t, input logic [31:0] a, input logic [31:0] r);
    int n = sz(t);
    int off = int'(a % 4) - int'(a % 4) % n;
    logic [31:0] v = (r >> (8 * off)) & mask(n);
    if ((t == 4'h0 || t == 4'h2) && v[8 * n - 1]) v = v | ~mask(n);
    return v;
  endfunction

  // scoreboard monitor: pops expectations whenever the DUT shows a grant, a done pulse or an exception
  always @(negedge clk) if (!rst) begin
    if (bus.req && bus.gnt) begin
      chk("gnt_expected", 32'(bus_q.size() > 0), 1);
      if (bus_q.size() > 0) begin
        mt = bus_q.pop_front();
        chk("dbus_we", bus.we, mt.we);
        chk("dbus_be", bus.be, mt.be);
        chk("dbus_addr", bus.addr, mt.addr);
        if (mt.we) chk("dbus_wdata", bus.wdata, mt.wdata);
      end
    end
    if (done) begin
      chk("done_expected", 32'(done_q.size() > 0), 1);
      if (done_q.size() > 0) chk("ld_data", ld_data, done_q.pop_front());
      chk("done_stall", stall_req, 0);
    end
    if (exc_adel || exc_ades) begin
      chk("exc_expected", 32'(exc_q.size() > 0), 1);
      if (exc_q.size() > 0) begin
        me = exc_q.pop_front();
        chk("exc_kind", {exc_ades, exc_adel}, me[32] ? 2 : 1);
        chk("bad_vaddr", bad_vaddr, me[31:0]);
      end
      chk("exc_stall", stall_req, 0);
      chk("exc_req", bus.req, 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int rdly, input logic [31:0] rd);
    chk("drain_stall", stall_req, 1);
    repeat (rdly) tick();
    bus.rvalid = 1;
    bus.rdata = rd;
    tick();
    bus.rvalid = 0;
    chk("drain_release", stall_req, 0);
    chk("drain_ld_hold", ld_data, model_ld);
  endtask

  // fmode: 0 none, 1 flush in REQ without gnt, 2 flush with gnt, 3 flush in WAIT, 4 flush at issue
  task automatic run_op(input logic [3:0] t, input logic [31:0] a, input logic [31:0] d,
                        input int gdly, input int rdly, input int fmode, input logic [31:0] rd);
    int n = sz(t);
    bit ld = t < 4'h8;
    int k = 0;
    op_type = t;
    op_addr = a;
    op_wdata = d;
    op_valid = 1;
    flush = fmode == 4;
    if (n == 0 || fmode == 4 || a % n != 0) begin
      if (n != 0 && fmode != 4) exc_q.push_back({!ld, a});
      #1;
      chk("no_stall", stall_req, 0);
      tick();
      op_valid = 0;
      flush = 0;
      chk("no_req", bus.req, 0);
      return;
    end
    #1;
    chk("issue_stall", stall_req, 1);
    tick();
    while (!bus.req && k < 4) begin
      tick();
      k++;
    end
    chk("req_seen", bus.req, 1);
    if (!bus.req) begin
      op_valid = 0;
      return;
    end
    if (fmode == 1) begin
      flush = 1;
      tick();
      flush = 0;
      op_valid = 0;
      chk("flush_req_drop", bus.req, 0);
      chk("flush_req_stall", stall_req, 0);
      return;
    end
    repeat (gdly) tick();
    chk("req_hold", bus.req, 1);
    bus_q.push_back('{!ld, 4'(((1 << n) - 1) << (int'(a % 4) - int'(a % 4) % n)), a & ~32'd3,
                      n == 1 ? d[7:0] * 32'h0101_0101 : n == 2 ? d[15:0] * 32'h0001_0001 : d});
    if (!ld && fmode != 2) done_q.push_back(model_ld);
    bus.gnt = 1;
    flush = fmode == 2;
    tick();
    bus.gnt = 0;
    flush = 0;
    if (fmode == 2) begin
      op_valid = 0;
      if (ld) drain(rdly, rd);
      else chk("flush_store_stall", stall_req, 0);
      return;
    end
    if (ld && fmode == 3) begin
      flush = 1;
      op_valid = 0;
      tick();
      flush = 0;
      drain(rdly, rd);
      return;
    end
    if (ld) begin
      repeat (rdly) tick();
      model_ld = ld_m(t, a, rd);
      done_q.push_back(model_ld);
      bus.rvalid = 1;
      bus.rdata = rd;
      tick();
      bus.rvalid = 0;
    end
    tick();
    op_valid = 0;
    tick();
    chk("no_reissue", bus.req, 0);
  endtask

  initial begin
    bus.gnt = 0;
    bus.rvalid = 0;
    bus.rdata = 0;
    tick();
    tick();
    chk("rst_stall", stall_req, 0);
    chk("rst_done", done, 0);
    chk("rst_req", bus.req, 0);
    chk("rst_we", bus.we, 0);
    chk("rst_be", bus.be, 0);
    chk("rst_addr", bus.addr, 0);
    chk("rst_wdata", bus.wdata, 0);
    chk("rst_ld_data", ld_data, 0);
    chk("rst_exc", {exc_ades, exc_adel}, 0);
    chk("rst_bad_vaddr", bad_vaddr, 0);
    rst = 0;
    tick();
    run_op(4'hA, 32'h100, 32'hDEADBEEF, 2, 0, 0, 0);
    run_op(4'h0, 32'h203, 0, 0, 0, 0, 32'h8012_3456);
    chk("lb_sext", ld_data, 32'hFFFF_FF80);
    run_op(4'h1, 32'h203, 0, 1, 1, 0, 32'h8012_3456);
    chk("lbu_zext", ld_data, 32'h0000_0080);
    run_op(4'h2, 32'h102, 0, 0, 0, 0, 32'h8001_7777);
    chk("lh_sext", ld_data, 32'hFFFF_8001);
    run_op(4'h4, 32'h101, 0, 0, 0, 0, 0);
    run_op(4'h8, 32'h1, 32'h0000_00AB, 0, 0, 0, 0);
    run_op(4'h9, 32'h3, 32'h1234, 0, 0, 0, 0);
    run_op(4'h4, 32'h200, 0, 1, 2, 2, 32'h5555_AAAA);
    run_op(4'h4, 32'h204, 0, 0, 1, 3, 32'h1111_2222);
    run_op(4'h4, 32'h208, 0, 0, 0, 1, 0);
    for (int i = 0; i < 250; i++) begin
      int r = $urandom_range(0, 9);
      run_op(4'($urandom_range(0, 15)), $urandom & 32'h0000_FFFF, $urandom, $urandom_range(0, 3),
             $urandom_range(0, 3), r < 6 ? 0 : r - 5, $urandom);
    end
    op_type = 4'h4;
    op_addr = 32'h40;
    op_valid = 1;
    tick();
    bus_q.push_back('{1'b0, 4'hF, 32'h40, 32'h0});
    bus.gnt = 1;
    tick();
    bus.gnt = 0;
    rst = 1;
    op_valid = 0;
    tick();
    rst = 0;
    model_ld = 0;
    chk("wrst_stall", stall_req, 0);
    chk("wrst_done", done, 0);
    chk("wrst_req", bus.req, 0);
    chk("wrst_be", bus.be, 0);
    chk("wrst_addr", bus.addr, 0);
    chk("wrst_ld_data", ld_data, 0);
    bus.rvalid = 1;
    bus.rdata = 32'hCAFE_F00D;
    tick();
    bus.rvalid = 0;
    tick();
    chk("wrst_ignore_rvalid", ld_data, 0);
    chk("wrst_idle_stall", stall_req, 0);
    chk("bus_q_empty", bus_q.size(), 0);
    chk("done_q_empty", done_q.size(), 0);
    chk("exc_q_empty", exc_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
